// File: rtl/lsu_mmio.sv
// rtl/lsu_mmio.sv - RV32I load/store unit with data memory and board I/O registers
//
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_lsu_addr, i_funct3      byte address and access size/signedness
//   i_st_data, i_lsu_wren     store data and store strobe
//   o_ld_data, o_misalign     combinational load result and misalignment flag
//   o_io_ledr/ledg/hex*/lcd   output registers
//   i_io_sw, i_io_btn         asynchronous board inputs (synchronized inside)
module lsu_mmio #(
  parameter int DMEM_BYTES = 8192,
  parameter int LEDR_W     = 17,
  parameter int LEDG_W     = 8,
  parameter int SW_W       = 18
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_lsu_addr,
  input  logic [31:0]       i_st_data,
  input  logic              i_lsu_wren,
  input  logic [2:0]        i_funct3,
  output logic [31:0]       o_ld_data,
  output logic              o_misalign,
  output logic [LEDR_W-1:0] o_io_ledr,
  output logic [LEDG_W-1:0] o_io_ledg,
  output logic [6:0]        o_io_hex0,
  output logic [6:0]        o_io_hex1,
  output logic [6:0]        o_io_hex2,
  output logic [6:0]        o_io_hex3,
  output logic [6:0]        o_io_hex4,
  output logic [6:0]        o_io_hex5,
  output logic [6:0]        o_io_hex6,
  output logic [6:0]        o_io_hex7,
  output logic [31:0]       o_io_lcd,
  input  logic [SW_W-1:0]   i_io_sw,
  input  logic [3:0]        i_io_btn
);

  localparam int AW    = $clog2(DMEM_BYTES);
  localparam int WORDS = DMEM_BYTES / 4;

  logic [31:0]       dmem [WORDS];
  logic [LEDR_W-1:0] ledr;
  logic [LEDG_W-1:0] ledg;
  logic [6:0]        hex [8];
  logic [31:0]       lcd;
  logic [SW_W-1:0]   sw_s1, sw_s2;
  logic [3:0]        btn_s1, btn_s2;

  // Address decode: DMEM needs every bit above its index range clear,
  // I/O registers match their whole 4 KiB page.
  logic [19:0]   page;
  logic [AW-3:0] widx;
  logic sel_dmem, sel_ledr, sel_ledg, sel_hexlo, sel_hexhi, sel_lcd, sel_sw, sel_btn;

  assign page      = i_lsu_addr[31:12];
  assign widx      = i_lsu_addr[AW-1:2];
  assign sel_dmem  = (i_lsu_addr[31:AW] == '0);
  assign sel_ledr  = (page == 20'h10000);
  assign sel_ledg  = (page == 20'h10001);
  assign sel_hexlo = (page == 20'h10002);
  assign sel_hexhi = (page == 20'h10003);
  assign sel_lcd   = (page == 20'h10004);
  assign sel_sw    = (page == 20'h10010);
  assign sel_btn   = (page == 20'h10011);

  logic is_half, is_word, ld_legal, st_legal;
  assign is_half    = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
  assign is_word    = (i_funct3 == 3'b010);
  assign ld_legal   = (i_funct3 == 3'b000) || (i_funct3 == 3'b100) || is_half || is_word;
  assign st_legal   = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || is_word;
  assign o_misalign = (is_half && i_lsu_addr[0]) || (is_word && (i_lsu_addr[1:0] != 2'b00));

  // Current contents of the selected 32-bit location, zero-padded.
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    if (sel_dmem)       rd_word = dmem[widx];
    else if (sel_ledr)  rd_word = 32'(ledr);
    else if (sel_ledg)  rd_word = 32'(ledg);
    else if (sel_hexlo) rd_word = {1'b0, hex[3], 1'b0, hex[2], 1'b0, hex[1], 1'b0, hex[0]};
    else if (sel_hexhi) rd_word = {1'b0, hex[7], 1'b0, hex[6], 1'b0, hex[5], 1'b0, hex[4]};
    else if (sel_lcd)   rd_word = lcd;
    else if (sel_sw)    rd_word = 32'(sw_s2);
    else if (sel_btn)   rd_word = 32'(btn_s2);
  end

  logic [31:0] shifted;
  assign shifted = rd_word >> {i_lsu_addr[1:0], 3'b000};

  always_comb begin
    o_ld_data = '0;
    if (!o_misalign && ld_legal) begin
      case (i_funct3)
        3'b000:  o_ld_data = {{24{shifted[7]}}, shifted[7:0]};
        3'b001:  o_ld_data = {{16{shifted[15]}}, shifted[15:0]};
        3'b100:  o_ld_data = {24'd0, shifted[7:0]};
        3'b101:  o_ld_data = {16'd0, shifted[15:0]};
        default: o_ld_data = rd_word;
      endcase
    end
  end

  // Store lanes: data is replicated across the word so each enabled byte
  // lane already carries the right byte.
  logic [3:0]  be;
  logic [31:0] wdata, mask, wr_word;
  logic        wr_en;

  always_comb begin
    be    = 4'b1111;
    wdata = i_st_data;
    if (i_funct3 == 3'b000) begin
      be    = 4'b0001 << i_lsu_addr[1:0];
      wdata = {4{i_st_data[7:0]}};
    end else if (i_funct3 == 3'b001) begin
      be    = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
      wdata = {2{i_st_data[15:0]}};
    end
  end

  assign mask    = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign wr_word = (rd_word & ~mask) | (wdata & mask);
  assign wr_en   = i_rst_n && i_lsu_wren && !o_misalign && st_legal;

  // DMEM keeps its contents through reset.
  always_ff @(posedge i_clk) begin
    if (wr_en && sel_dmem) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) dmem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ledr   <= '0;
      ledg   <= '0;
      lcd    <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
      btn_s1 <= '0;
      btn_s2 <= '0;
      for (int i = 0; i < 8; i++) hex[i] <= '0;
    end else begin
      sw_s1  <= i_io_sw;
      sw_s2  <= sw_s1;
      btn_s1 <= i_io_btn;
      btn_s2 <= btn_s1;
      if (wr_en) begin
        if (sel_ledr) ledr <= wr_word[LEDR_W-1:0];
        if (sel_ledg) ledg <= wr_word[LEDG_W-1:0];
        if (sel_lcd)  lcd  <= wr_word;
        if (sel_hexlo) for (int i = 0; i < 4; i++) hex[i]   <= wr_word[8*i +: 7];
        if (sel_hexhi) for (int i = 0; i < 4; i++) hex[i+4] <= wr_word[8*i +: 7];
      end
    end
  end

  assign o_io_ledr = ledr;
  assign o_io_ledg = ledg;
  assign o_io_lcd  = lcd;
  assign o_io_hex0 = hex[0];
  assign o_io_hex1 = hex[1];
  assign o_io_hex2 = hex[2];
  assign o_io_hex3 = hex[3];
  assign o_io_hex4 = hex[4];
  assign o_io_hex5 = hex[5];
  assign o_io_hex6 = hex[6];
  assign o_io_hex7 = hex[7];

endmodule
